// File: rtl/cpu_reg_master.sv
// Initiator end of the CPU register bus: accepts one register request at a time,
// issues a single write or read strobe to the slaves, and returns one response.
module cpu_reg_master #(
    parameter int ADDR_WIDTH = 20,
    parameter int RD_LAT     = 2
) (
    input  logic                  clks,
    input  logic                  reset,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic                  rsp_wr,
    output logic [31:0]           rsp_rdata,
    output logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [31:0]           cpu_data,
    output logic                  cpu_wr,
    output logic                  cpu_rd,
    input  logic [31:0]           cpu_rdata
);

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RSP} state_e;

    localparam logic [3:0] RD_LAT_INIT = 4'(RD_LAT);

    // The 4-bit latency counter only covers 1..15; anything else is unusable.
    generate
        if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
            $fatal(1, "cpu_reg_master: RD_LAT=%0d outside legal range 1..15", RD_LAT);
        end
    endgenerate

    state_e                  state_q,     state_d;
    logic                    req_rdy_q,   req_rdy_d;
    logic                    rsp_vld_q,   rsp_vld_d;
    logic                    rsp_wr_q,    rsp_wr_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0]   cpu_addr_q,  cpu_addr_d;
    logic [31:0]             cpu_data_q,  cpu_data_d;
    logic                    cpu_wr_q,    cpu_wr_d;
    logic                    cpu_rd_q,    cpu_rd_d;
    logic [3:0]              cnt_q,       cnt_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        req_rdy_d   = req_rdy_q;
        rsp_vld_d   = rsp_vld_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_data_d  = cpu_data_q;
        cpu_wr_d    = 1'b0;
        cpu_rd_d    = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    cpu_addr_d = req_addr;
                    req_rdy_d  = 1'b0;
                    if (req_wr) begin
                        cpu_data_d = req_wdata;
                        cpu_wr_d   = 1'b1;
                        state_d    = WR;
                    end else begin
                        cpu_rd_d   = 1'b1;
                        cnt_d      = RD_LAT_INIT;
                        state_d    = RD_WAIT;
                    end
                end
            end
            WR: begin
                rsp_vld_d   = 1'b1;
                rsp_wr_d    = 1'b1;
                rsp_rdata_d = 32'h0;
                state_d     = RSP;
            end
            RD_WAIT: begin
                // Sampling on the edge that sees the counter at zero puts capture RD_LAT edges after the strobe edge.
                if (cnt_q == 4'd0) begin
                    rsp_vld_d   = 1'b1;
                    rsp_wr_d    = 1'b0;
                    rsp_rdata_d = cpu_rdata;
                    state_d     = RSP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RSP: begin
                if (rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                    req_rdy_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clks) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            req_rdy_q   <= 1'b1;
            rsp_vld_q   <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= 32'h0;
            cpu_addr_q  <= '0;
            cpu_data_q  <= 32'h0;
            cpu_wr_q    <= 1'b0;
            cpu_rd_q    <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            req_rdy_q   <= req_rdy_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_data_q  <= cpu_data_d;
            cpu_wr_q    <= cpu_wr_d;
            cpu_rd_q    <= cpu_rd_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_rdy   = req_rdy_q;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign cpu_addr  = cpu_addr_q;
    assign cpu_data  = cpu_data_q;
    assign cpu_wr    = cpu_wr_q;
    assign cpu_rd    = cpu_rd_q;

endmodule

// File: tb/tb_cpu_reg_master.sv
// Bench for cpu_reg_master: directed vector table, hand sequences for the
// multi-cycle corners, and a randomized run against a register-file model.
module tb_cpu_reg_master;

    localparam int AW  = 20;
    localparam int LAT = 2;

    logic            clks = 1'b0;
    logic            reset;
    logic            req_vld, req_rdy, req_wr;
    logic [AW-1:0]   req_addr;
    logic [31:0]     req_wdata;
    logic            rsp_vld, rsp_rdy, rsp_wr;
    logic [31:0]     rsp_rdata;
    logic [AW-1:0]   cpu_addr;
    logic [31:0]     cpu_data;
    logic            cpu_wr, cpu_rd;
    logic [31:0]     cpu_rdata;

    // Extra instances for the latency sweep: index 0 is RD_LAT=1, index 1 is RD_LAT=15.
    logic [1:0]      l_req_vld, l_req_rdy, l_req_wr, l_rsp_vld, l_rsp_rdy, l_rsp_wr, l_cpu_wr, l_cpu_rd;
    logic [AW-1:0]   l_req_addr  [2];
    logic [31:0]     l_req_wdata [2];
    logic [31:0]     l_rsp_rdata [2];
    logic [AW-1:0]   l_cpu_addr  [2];
    logic [31:0]     l_cpu_data  [2];
    logic [31:0]     l_cpu_rdata [2];

    always #5 clks = ~clks;

    cpu_reg_master #(.ADDR_WIDTH(AW), .RD_LAT(LAT)) u_dut (
        .clks(clks), .reset(reset),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_rdata(cpu_rdata)
    );

    cpu_reg_master #(.ADDR_WIDTH(AW), .RD_LAT(1)) u_lat1 (
        .clks(clks), .reset(reset),
        .req_vld(l_req_vld[0]), .req_rdy(l_req_rdy[0]), .req_wr(l_req_wr[0]),
        .req_addr(l_req_addr[0]), .req_wdata(l_req_wdata[0]),
        .rsp_vld(l_rsp_vld[0]), .rsp_rdy(l_rsp_rdy[0]), .rsp_wr(l_rsp_wr[0]), .rsp_rdata(l_rsp_rdata[0]),
        .cpu_addr(l_cpu_addr[0]), .cpu_data(l_cpu_data[0]), .cpu_wr(l_cpu_wr[0]), .cpu_rd(l_cpu_rd[0]),
        .cpu_rdata(l_cpu_rdata[0])
    );

    cpu_reg_master #(.ADDR_WIDTH(AW), .RD_LAT(15)) u_lat15 (
        .clks(clks), .reset(reset),
        .req_vld(l_req_vld[1]), .req_rdy(l_req_rdy[1]), .req_wr(l_req_wr[1]),
        .req_addr(l_req_addr[1]), .req_wdata(l_req_wdata[1]),
        .rsp_vld(l_rsp_vld[1]), .rsp_rdy(l_rsp_rdy[1]), .rsp_wr(l_rsp_wr[1]), .rsp_rdata(l_rsp_rdata[1]),
        .cpu_addr(l_cpu_addr[1]), .cpu_data(l_cpu_data[1]), .cpu_wr(l_cpu_wr[1]), .cpu_rd(l_cpu_rd[1]),
        .cpu_rdata(l_cpu_rdata[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clks);
        #1;
    endtask

    // Register-slave model: stores on cpu_wr, returns data RD_LAT edges after the cpu_rd edge.
    logic [31:0] smem [logic [AW-1:0]];

    initial begin : slave
        int            s_cnt;
        logic [AW-1:0] s_addr;
        s_cnt     = -1;
        s_addr    = '0;
        cpu_rdata = 32'h0;
        forever begin
            @(negedge clks);
            if (cpu_wr) smem[cpu_addr] = cpu_data;
            if (cpu_rd) begin
                s_cnt  = LAT - 1;
                s_addr = cpu_addr;
            end
            @(posedge clks);
            #1;
            if (s_cnt == 0) begin
                cpu_rdata = smem.exists(s_addr) ? smem[s_addr] : 32'h0;
                s_cnt     = -1;
            end else begin
                cpu_rdata = 32'h0;
                if (s_cnt > 0) s_cnt--;
            end
        end
    end

    // Strobe monitor: logs pulses with their cycle and checks the one-hot / one-cycle rules.
    int   cyc;
    int   ev_kind[$];
    int   ev_cyc[$];
    logic prev_wr, prev_rd;

    initial begin : monitor
        cyc     = 0;
        prev_wr = 1'b0;
        prev_rd = 1'b0;
        forever begin
            @(negedge clks);
            cyc++;
            if (!reset) begin
                if (cpu_wr || cpu_rd || prev_wr || prev_rd) begin
                    check("strobe_overlap", 32'(cpu_wr & cpu_rd), 32'd0);
                    check("wr_consecutive", 32'(prev_wr & cpu_wr), 32'd0);
                    check("rd_consecutive", 32'(prev_rd & cpu_rd), 32'd0);
                end
                if (cpu_wr) begin ev_kind.push_back(1); ev_cyc.push_back(cyc); end
                if (cpu_rd) begin ev_kind.push_back(2); ev_cyc.push_back(cyc); end
            end
            prev_wr = cpu_wr;
            prev_rd = cpu_rd;
        end
    end

    task automatic wait_rdy(input string name);
        int n;
        n = 0;
        while (!req_rdy && n < 60) begin tick(); n++; end
        check(name, 32'(req_rdy), 32'd1);
    endtask

    // One full transaction with cycle-exact checks; rsp_rdy is held high.
    task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata);
        int wait_cyc;
        wait_rdy("txn_rdy");
        req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; rsp_rdy = 1'b1;
        tick();
        req_vld = 1'b0; req_addr = ~addr; req_wdata = ~wdata;
        check("acc_req_rdy", 32'(req_rdy), 32'd0);
        check("acc_cpu_wr", 32'(cpu_wr), 32'(wr));
        check("acc_cpu_rd", 32'(cpu_rd), 32'(!wr));
        check("acc_cpu_addr", 32'(cpu_addr), 32'(addr));
        if (wr) check("acc_cpu_data", cpu_data, wdata);
        wait_cyc = wr ? 1 : 1 + LAT;
        for (int i = 1; i < wait_cyc; i++) begin
            tick();
            check("wait_rsp_vld", 32'(rsp_vld), 32'd0);
            check("wait_strobes", 32'(cpu_wr | cpu_rd), 32'd0);
            check("wait_addr_hold", 32'(cpu_addr), 32'(addr));
        end
        tick();
        check("rsp_vld", 32'(rsp_vld), 32'd1);
        check("rsp_wr", 32'(rsp_wr), 32'(wr));
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_addr_hold", 32'(cpu_addr), 32'(addr));
        tick();
        check("post_rsp_vld", 32'(rsp_vld), 32'd0);
        check("post_req_rdy", 32'(req_rdy), 32'd1);
    endtask

    // Read on a sweep instance with bus data present only in one cycle, offset by shift.
    task automatic lat_probe(input int k, input int lat, input int shift);
        logic [31:0] val;
        val = 32'hC0DE_0000 | 32'(lat);
        check("lat_req_rdy", 32'(l_req_rdy[k]), 32'd1);
        l_req_vld[k] = 1'b1; l_req_wr[k] = 1'b0; l_req_addr[k] = 20'h00040;
        l_rsp_rdy[k] = 1'b1; l_cpu_rdata[k] = 32'h0;
        tick();
        l_req_vld[k] = 1'b0;
        check("lat_cpu_rd", 32'(l_cpu_rd[k]), 32'd1);
        for (int c = 1; c <= lat + 2; c++) begin
            l_cpu_rdata[k] = (c == lat + 1 + shift) ? val : 32'h0;
            tick();
            if (c <= lat) begin
                check("lat_early_vld", 32'(l_rsp_vld[k]), 32'd0);
            end else if (c == lat + 1) begin
                check("lat_rsp_vld", 32'(l_rsp_vld[k]), 32'd1);
                check("lat_rdata", l_rsp_rdata[k], (shift == 0) ? val : 32'h0);
            end else begin
                check("lat_done_vld", 32'(l_rsp_vld[k]), 32'd0);
            end
        end
        l_cpu_rdata[k] = 32'h0;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
    } vec_t;

    vec_t vecs[8];

    logic [31:0] ref_mem [logic [AW-1:0]];

    initial begin : main
        int   n;
        int   ev_n;
        logic seen;
        reset = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = 32'h0; rsp_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            l_req_vld[k] = 1'b0; l_req_wr[k] = 1'b0; l_req_addr[k] = '0; l_req_wdata[k] = 32'h0;
            l_rsp_rdy[k] = 1'b0; l_cpu_rdata[k] = 32'h0;
        end
        repeat (3) tick();
        check("rst_req_rdy", 32'(req_rdy), 32'd1);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rsp_wr", 32'(rsp_wr), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_cpu_addr", 32'(cpu_addr), 32'h0);
        check("rst_cpu_data", cpu_data, 32'h0);
        check("rst_cpu_wr", 32'(cpu_wr), 32'd0);
        check("rst_cpu_rd", 32'(cpu_rd), 32'd0);
        reset = 1'b0;
        tick();

        smem[20'h00020] = 32'h1234_5678;
        smem[20'h00030] = 32'hDEAD_BEEF;
        vecs[0] = '{1'b1, 20'h00010, 32'hA5A5_0001, 32'h0};
        vecs[1] = '{1'b0, 20'h00020, 32'h0,         32'h1234_5678};
        vecs[2] = '{1'b0, 20'h00010, 32'h0,         32'hA5A5_0001};
        vecs[3] = '{1'b1, 20'hFFFFF, 32'hFFFF_FFFF, 32'h0};
        vecs[4] = '{1'b0, 20'hFFFFF, 32'h0,         32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 20'h00000, 32'h0000_0000, 32'h0};
        vecs[6] = '{1'b0, 20'h00000, 32'h0,         32'h0};
        vecs[7] = '{1'b0, 20'h00050, 32'h0,         32'h0};
        for (int i = 0; i < 8; i++) do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // Backpressure: response held 5 cycles, a competing request must wait.
        wait_rdy("bp_rdy");
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 20'h00030; rsp_rdy = 1'b0;
        tick();
        req_vld = 1'b0;
        n = 0;
        while (!rsp_vld && n < 40) begin tick(); n++; end
        check("bp_rsp_arrive", 32'(rsp_vld), 32'd1);
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 20'h00044; req_wdata = 32'h5555_AAAA;
        ev_n = ev_kind.size();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_vld", 32'(rsp_vld), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            check("bp_rsp_wr", 32'(rsp_wr), 32'd0);
            check("bp_req_rdy", 32'(req_rdy), 32'd0);
            tick();
        end
        rsp_rdy = 1'b1;
        tick();
        check("bp_hs_vld", 32'(rsp_vld), 32'd0);
        check("bp_hs_rdy", 32'(req_rdy), 32'd1);
        check("bp_no_strobes", 32'(ev_kind.size()), 32'(ev_n));
        tick();
        req_vld = 1'b0;
        check("bp_accept_wr", 32'(cpu_wr), 32'd1);
        check("bp_accept_addr", 32'(cpu_addr), 32'h00044);
        check("bp_accept_data", cpu_data, 32'h5555_AAAA);
        tick();
        check("bp_wr_rsp", 32'(rsp_vld & rsp_wr), 32'd1);
        tick();

        // Back-to-back: W, W, W, R with req_vld held high.
        ev_kind.delete();
        ev_cyc.delete();
        rsp_rdy = 1'b1;
        req_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_wr    = (i < 3);
            req_addr  = 20'h00100 + 20'(i * 4);
            req_wdata = 32'hB000_0000 + 32'(i);
            n = 0;
            while (!req_rdy && n < 20) begin tick(); n++; end
            check("b2b_rdy", 32'(req_rdy), 32'd1);
            tick();
        end
        req_vld = 1'b0;
        repeat (LAT + 4) tick();
        check("b2b_count", 32'(ev_kind.size()), 32'd4);
        if (ev_kind.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("b2b_order", 32'(ev_kind[i]), (i < 3) ? 32'd1 : 32'd2);
            for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(ev_cyc[i] - ev_cyc[i-1]), 32'd3);
        end

        // Reset while a read is in flight.
        wait_rdy("rst_mid_rdy");
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 20'h00020; rsp_rdy = 1'b1;
        tick();
        req_vld = 1'b0;
        check("rst_mid_rd_issued", 32'(cpu_rd), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_mid_cpu_rd", 32'(cpu_rd), 32'd0);
        check("rst_mid_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_mid_req_rdy", 32'(req_rdy), 32'd1);
        reset = 1'b0;
        seen = 1'b0;
        repeat (LAT + 6) begin
            tick();
            if (rsp_vld) seen = 1'b1;
        end
        check("rst_mid_no_rsp", 32'(seen), 32'd0);

        // Latency sweep: only the exact sampling cycle may be captured.
        for (int s = -1; s <= 1; s++) begin
            lat_probe(0, 1, s);
            lat_probe(1, 15, s);
        end

        // Randomized run against a flat register-file model.
        smem.delete();
        ref_mem.delete();
        for (int t = 0; t < 60; t++) begin
            logic          wr, done, got;
            logic [AW-1:0] addr;
            logic [31:0]   wdata, exp_rd;
            wr    = 1'($urandom_range(0, 1));
            addr  = (20'($urandom_range(0, 7)) << 4) | (($urandom_range(0, 1) == 1) ? 20'h80000 : 20'h0);
            wdata = $urandom;
            if (wr) begin
                ref_mem[addr] = wdata;
                exp_rd = 32'h0;
            end else begin
                exp_rd = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
            end
            repeat ($urandom_range(0, 2)) tick();
            wait_rdy("rnd_rdy");
            req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
            tick();
            req_vld = 1'b0;
            n = 0; got = 1'b0; done = 1'b0;
            while (!done && n < 60) begin
                rsp_rdy = 1'($urandom_range(0, 1));
                if (rsp_vld) begin
                    if (!got) begin
                        check("rnd_rsp_wr", 32'(rsp_wr), 32'(wr));
                        check("rnd_rsp_rdata", rsp_rdata, exp_rd);
                        got = 1'b1;
                    end
                    if (rsp_rdy) done = 1'b1;
                end
                tick();
                n++;
            end
            check("rnd_done", 32'(done), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_reg_master.md
Name: cpu_reg_master

Overview:
- Initiator end of the CPU register bus that the cmd/status register instances sit on.
- Accepts one register request at a time on a valid/ready request channel and drives cpu_addr / cpu_data / cpu_wr / cpu_rd toward the register slaves.
- For reads, waits a fixed read latency and captures the OR-combined slave read bus.
- Returns a single response per request on a valid/ready response channel.
- Sits between the host-side access bridge and the register-file decode.

Parameters:
- ADDR_WIDTH, 20, width of request and bus address.
- RD_LAT, 2, cycles from the cpu_rd assertion edge to the cpu_rdata sampling edge; legal range 1..15.

Ports:
- clks  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready; high only in IDLE.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  register address.
- req_wdata  in  32  write data; ignored for reads.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_wr  out  1  echo of req_wr for this response.
- rsp_rdata  out  32  read data; 0 for write responses.
- cpu_addr  out  ADDR_WIDTH  bus address to slaves.
- cpu_data  out  32  bus write data to slaves (their cpu_data_in).
- cpu_wr  out  1  one-cycle write strobe.
- cpu_rd  out  1  one-cycle read strobe.
- cpu_rdata  in  32  OR-combined slave read data (their cpu_data_out).

Behaviour:
- Reset values:
  - FSM = IDLE, req_rdy = 1, rsp_vld = 0, rsp_wr = 0.
  - rsp_rdata = 0, cpu_addr = 0, cpu_data = 0, cpu_wr = 0, cpu_rd = 0, latency counter = 0.
- All outputs are registered.
- FSM states: IDLE, WR, RD_WAIT, RSP.
- IDLE:
  - req_rdy = 1.
  - On req_vld at edge T: latch req_addr into cpu_addr, req_wdata into cpu_data (write only), and req_wr.
  - Go to WR if req_wr = 1; else go to RD_WAIT and load counter = RD_LAT.
  - req_rdy drops at T+1.
- WR:
  - cpu_wr = 1 for exactly the one cycle following T.
  - Next state RSP, with rsp_wr = 1 and rsp_rdata = 0.
- RD_WAIT:
  - cpu_rd = 1 only in the first cycle after T.
  - cpu_addr is held stable for the whole wait.
  - Counter decrements each cycle; cpu_rdata is sampled into rsp_rdata on the edge where the counter reaches 0, i.e. edge T+1+RD_LAT.
  - Next state RSP, with rsp_wr = 0.
- RSP:
  - rsp_vld = 1; rsp_wr and rsp_rdata are held stable until rsp_rdy = 1.
  - On handshake return to IDLE; rsp_vld = 0 and req_rdy = 1 on the next cycle.
- Latency:
  - Write: cpu_wr asserted cycle T+1, rsp_vld at T+2.
  - Read: cpu_rd at T+1, rsp_vld at T+2+RD_LAT.
  - Minimum request-to-request spacing is 3 cycles for a write with rsp_rdy tied high.
- Exactly one outstanding request; req_vld while req_rdy = 0 is ignored and not latched.
- Address/data hold: cpu_addr and cpu_data keep their last values in IDLE and RSP. Slaves qualify on strobes only, so no bus return-to-zero is required.
- cpu_wr and cpu_rd are never high together and never high for more than one consecutive cycle.
- Reset mid-operation:
  - At the next edge: FSM = IDLE, strobes = 0, any pending response is discarded (rsp_vld = 0).
  - A cpu_wr already issued is not revoked.
- rsp_rdy asserted while rsp_vld = 0 has no effect.
- RD_LAT outside 1..15 is a configuration error; simulation must flag it at time 0.

Test Plan:
- Write: reset, then req_vld=1, req_wr=1, req_addr=0x00010, req_wdata=0xA5A5_0001, rsp_rdy=1 → cpu_wr high exactly at T+1 with cpu_addr=0x00010 and cpu_data=0xA5A5_0001; rsp_vld at T+2 with rsp_wr=1 and rsp_rdata=0.
- Read, RD_LAT=2: cpu_rdata model returns 0x1234_5678 two cycles after cpu_rd for addr 0x00020 → cpu_rd pulse at T+1; rsp_vld at T+4 with rsp_rdata=0x1234_5678 and rsp_wr=0; cpu_addr stable T+1..T+4.
- Backpressure: rsp_rdy=0 for 5 cycles after a read of 0xDEAD_BEEF → rsp_vld and rsp_rdata held for 5 cycles; a second req_vld during that window is not accepted (req_rdy=0, no strobes); it is accepted one cycle after the response handshake.
- Back-to-back: three writes then one read with req_vld held high and rsp_rdy=1 → exactly 3 cpu_wr pulses and 1 cpu_rd pulse, in order; writes spaced 3 cycles apart; cpu_wr and cpu_rd never overlap.
- Reset mid-read: assert reset during RD_WAIT → next edge: cpu_rd=0, rsp_vld=0, req_rdy=1; no response is ever produced for that read.
- Parameter sweep RD_LAT=1 and RD_LAT=15: rsp_rdata captures bus data exactly RD_LAT edges after the cpu_rd edge; data driven one cycle earlier or later must not be captured.
